// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read, write, debug-peek and dump-stream bundle for regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] du_reg_addr;
  logic [DATA_W-1:0] du_reg_data;
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, du_reg_addr,
           dump_start, dump_ready,
    input  rs_data, rt_data, du_reg_data, dump_valid, dump_addr,
           dump_data, dump_busy, dump_done
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, du_reg_addr,
           dump_start, dump_ready,
    output rs_data, rt_data, du_reg_data, dump_valid, dump_addr,
           dump_data, dump_busy, dump_done
  );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised 2R/1W register file with write bypass and dump engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  regfile_mp_if.slave bus
);

  localparam int                c_NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST  = '1;
  localparam logic [ADDR_W-1:0] c_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_regs [c_NREGS];
  state_t            r_state;
  logic              r_dump_valid;
  logic              r_dump_busy;
  logic              r_dump_done;
  logic [ADDR_W-1:0] r_dump_addr;
  logic              w_wr_ok;

  // A write to r0 is dropped entirely when r0 is hardwired, including for bypass.
  assign w_wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  function automatic logic [DATA_W-1:0] f_sel(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] arr,
    input logic              byp,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if (byp && (BYPASS != 0) && we && (wa == a)) return wd;
    return arr;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rs_data     = f_sel(bus.rs_addr, r_regs[bus.rs_addr], 1'b1,
                                 w_wr_ok, bus.wr_addr, bus.wr_data);
  assign bus.rt_data     = f_sel(bus.rt_addr, r_regs[bus.rt_addr], 1'b1,
                                 w_wr_ok, bus.wr_addr, bus.wr_data);
  assign bus.du_reg_data = f_sel(bus.du_reg_addr, r_regs[bus.du_reg_addr], 1'b0,
                                 w_wr_ok, bus.wr_addr, bus.wr_data);
  assign bus.dump_data   = f_sel(r_dump_addr, r_regs[r_dump_addr], 1'b1,
                                 w_wr_ok, bus.wr_addr, bus.wr_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
      r_dump_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dump_done <= 1'b0;
          if (bus.dump_start) begin
            r_state      <= S_SEND;
            r_dump_valid <= 1'b1;
            r_dump_busy  <= 1'b1;
            r_dump_addr  <= '0;
          end
        end
        S_SEND: begin
          if (bus.dump_ready) begin
            if (r_dump_addr == c_LAST) begin
              r_state      <= S_DONE;
              r_dump_valid <= 1'b0;
              r_dump_done  <= 1'b1;
            end else begin
              r_dump_addr <= r_dump_addr + c_ONE;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_dump_done <= 1'b0;
          r_dump_busy <= 1'b0;
          r_dump_addr <= '0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_dump_valid <= 1'b0;
          r_dump_busy  <= 1'b0;
          r_dump_done  <= 1'b0;
          r_dump_addr  <= '0;
        end
      endcase
    end
  end

  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_busy  = r_dump_busy;
  assign bus.dump_done  = r_dump_done;
  assign bus.dump_addr  = r_dump_addr;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed bench for regfile_mp across zero-register/bypass variants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr, du_addr;
  logic [31:0] wr_data;
  logic        wr_en, dump_start, dump_ready;
  int          checks;
  int          errors;

  // Three variants: default, ordinary r0, no bypass.
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus    ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_nz ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

  assign bus.rs_addr = rs_addr;        assign bus_nz.rs_addr = rs_addr;        assign bus_nb.rs_addr = rs_addr;
  assign bus.rt_addr = rt_addr;        assign bus_nz.rt_addr = rt_addr;        assign bus_nb.rt_addr = rt_addr;
  assign bus.wr_en = wr_en;            assign bus_nz.wr_en = wr_en;            assign bus_nb.wr_en = wr_en;
  assign bus.wr_addr = wr_addr;        assign bus_nz.wr_addr = wr_addr;        assign bus_nb.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;        assign bus_nz.wr_data = wr_data;        assign bus_nb.wr_data = wr_data;
  assign bus.du_reg_addr = du_addr;    assign bus_nz.du_reg_addr = du_addr;    assign bus_nb.du_reg_addr = du_addr;
  assign bus.dump_start = dump_start;  assign bus_nz.dump_start = 1'b0;        assign bus_nb.dump_start = 1'b0;
  assign bus.dump_ready = dump_ready;  assign bus_nz.dump_ready = 1'b1;        assign bus_nb.dump_ready = 1'b1;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dut_nz (
    .clk(clk), .reset_n(reset_n), .bus(bus_nz.slave));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .bus(bus_nb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic test_reset;
    wr(5'd3, 32'h33); wr(5'd31, 32'h3131); wr(5'd7, 32'h77);
    @(negedge clk);
    wr_en = 1'b0; rs_addr = 5'd3; rt_addr = 5'd31; du_addr = 5'd7;
    #1;
    checks++; if (bus.rs_data !== 32'h33) begin errors++; $display("FAIL pre_reset_rs: got %h expected %h", bus.rs_data, 32'h33); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs: got %h expected 0", bus.rs_data); end
    checks++; if (bus.rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt: got %h expected 0", bus.rt_data); end
    checks++; if (bus.du_reg_data !== 32'h0) begin errors++; $display("FAIL reset_du: got %h expected 0", bus.du_reg_data); end
    checks++; if (bus.dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.dump_valid); end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.dump_busy); end
    checks++; if (bus.dump_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.dump_done); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_zero;
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd0, 32'h1234);
    @(negedge clk);
    wr_en = 1'b0; rs_addr = 5'd5; rt_addr = 5'd0; du_addr = 5'd0;
    #1;
    checks++; if (bus.rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rs5: got %h expected %h", bus.rs_data, 32'hDEADBEEF); end
    checks++; if (bus.rt_data !== 32'h0) begin errors++; $display("FAIL wr_rt0_zero: got %h expected 0", bus.rt_data); end
    checks++; if (bus.du_reg_data !== 32'h0) begin errors++; $display("FAIL wr_du0_zero: got %h expected 0", bus.du_reg_data); end
    checks++; if (bus_nz.rt_data !== 32'h1234) begin errors++; $display("FAIL wr_rt0_nozero: got %h expected %h", bus_nz.rt_data, 32'h1234); end
    checks++; if (bus_nz.du_reg_data !== 32'h1234) begin errors++; $display("FAIL wr_du0_nozero: got %h expected %h", bus_nz.du_reg_data, 32'h1234); end
    checks++; if (bus_nb.rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rs5_nobyp: got %h expected %h", bus_nb.rs_data, 32'hDEADBEEF); end
  endtask

  task automatic test_bypass;
    wr(5'd9, 32'h99);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    rs_addr = 5'd9; rt_addr = 5'd9; du_addr = 5'd9;
    #1;
    checks++; if (bus.rs_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_rs: got %h expected %h", bus.rs_data, 32'hA5A5A5A5); end
    checks++; if (bus.rt_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_rt: got %h expected %h", bus.rt_data, 32'hA5A5A5A5); end
    checks++; if (bus.du_reg_data !== 32'h99) begin errors++; $display("FAIL byp_du_old: got %h expected %h", bus.du_reg_data, 32'h99); end
    checks++; if (bus_nb.rs_data !== 32'h99) begin errors++; $display("FAIL nobyp_rs_old: got %h expected %h", bus_nb.rs_data, 32'h99); end
    checks++; if (bus_nb.rt_data !== 32'h99) begin errors++; $display("FAIL nobyp_rt_old: got %h expected %h", bus_nb.rt_data, 32'h99); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    checks++; if (bus_nb.rs_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL nobyp_rs_next: got %h expected %h", bus_nb.rs_data, 32'hA5A5A5A5); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; rs_addr = 5'd0;
    #1;
    checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL byp_r0_dropped: got %h expected 0", bus.rs_data); end
    checks++; if (bus_nz.rs_data !== 32'hFFFF) begin errors++; $display("FAIL byp_r0_nozero: got %h expected %h", bus_nz.rs_data, 32'hFFFF); end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_full_dump;
    int beat;
    int done_cyc;
    beat = 0; done_cyc = 0;
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) * 32'h11);
    @(negedge clk);
    wr_en = 1'b0; dump_ready = 1'b1; dump_start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      dump_start = 1'b0;
      #1;
      if (c == 1) begin
        checks++; if (bus.dump_busy !== 1'b1) begin errors++; $display("FAIL dump_busy_start: got %b expected 1", bus.dump_busy); end
      end
      if (bus.dump_done === 1'b1) begin done_cyc = c; break; end
      if (bus.dump_valid === 1'b1 && dump_ready) begin
        checks++;
        if (bus.dump_addr !== 5'(beat) || bus.dump_data !== 32'(beat) * 32'h11) begin
          errors++;
          $display("FAIL dump_beat: got addr %0d data %h expected addr %0d data %h",
                   bus.dump_addr, bus.dump_data, beat, 32'(beat) * 32'h11);
        end
        beat++;
      end
    end
    checks++; if (beat != 32) begin errors++; $display("FAIL dump_beats: got %0d expected 32", beat); end
    checks++; if (done_cyc != 33) begin errors++; $display("FAIL dump_latency: got %0d expected 33", done_cyc); end
    checks++; if (bus.dump_valid !== 1'b0) begin errors++; $display("FAIL dump_done_valid: got %b expected 0", bus.dump_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.dump_done !== 1'b0) begin errors++; $display("FAIL dump_done_width: got %b expected 0", bus.dump_done); end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL dump_idle_busy: got %b expected 0", bus.dump_busy); end
    checks++; if (bus.dump_addr !== 5'd0) begin errors++; $display("FAIL dump_idle_addr: got %0d expected 0", bus.dump_addr); end
  endtask

  task automatic test_backpressure;
    int   beat;
    int   done_cyc;
    bit   stalled;
    logic [31:0] exp_d;
    beat = 0; done_cyc = 0; stalled = 1'b0;
    @(negedge clk);
    dump_ready = 1'b0; dump_start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      wr_en = 1'b0;
      dump_start = (c == 15);
      if (bus.dump_valid === 1'b1 && bus.dump_addr == 5'd4 && !stalled) begin
        dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77; stalled = 1'b1;
        #1;
        checks++; if (bus.dump_data !== 32'h77) begin errors++; $display("FAIL bp_stall_data: got %h expected %h", bus.dump_data, 32'h77); end
      end else begin
        dump_ready = 1'($urandom_range(0, 1));
        #1;
      end
      if (bus.dump_done === 1'b1) begin done_cyc = c; break; end
      if (bus.dump_valid === 1'b1 && dump_ready) begin
        exp_d = (beat == 4) ? 32'h77 : 32'(beat) * 32'h11;
        checks++;
        if (bus.dump_addr !== 5'(beat) || bus.dump_data !== exp_d) begin
          errors++;
          $display("FAIL bp_beat: got addr %0d data %h expected addr %0d data %h",
                   bus.dump_addr, bus.dump_data, beat, exp_d);
        end
        beat++;
      end
    end
    wr_en = 1'b0; dump_start = 1'b0;
    checks++; if (!stalled) begin errors++; $display("FAIL bp_stall_seen: got 0 expected 1"); end
    checks++; if (beat != 32) begin errors++; $display("FAIL bp_beats: got %0d expected 32", beat); end
    checks++; if (done_cyc == 0) begin errors++; $display("FAIL bp_done_timeout: got no done expected done"); end
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: got busy %b expected 0", bus.dump_busy); end
  endtask

  task automatic test_reset_mid_dump;
    int beat;
    int done_cyc;
    bit hit;
    beat = 0; done_cyc = 0; hit = 1'b0;
    @(negedge clk);
    dump_ready = 1'b1; dump_start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      dump_start = 1'b0;
      #1;
      if (bus.dump_valid === 1'b1 && bus.dump_addr == 5'd10) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_reach_beat10: got 0 expected 1"); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.dump_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.dump_valid); end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.dump_busy); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.dump_done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b expected 0", bus.dump_done); end
    end
    reset_n = 1'b1;
    @(negedge clk);
    dump_start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      dump_start = 1'b0;
      #1;
      if (bus.dump_done === 1'b1) begin done_cyc = c; break; end
      if (bus.dump_valid === 1'b1 && dump_ready) begin
        checks++;
        if (bus.dump_addr !== 5'(beat) || bus.dump_data !== 32'h0) begin
          errors++;
          $display("FAIL mid_restart_beat: got addr %0d data %h expected addr %0d data 0",
                   bus.dump_addr, bus.dump_data, beat);
        end
        beat++;
      end
    end
    checks++; if (beat != 32) begin errors++; $display("FAIL mid_restart_beats: got %0d expected 32", beat); end
    checks++; if (done_cyc != 33) begin errors++; $display("FAIL mid_restart_latency: got %0d expected 33", done_cyc); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; du_addr = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_write_zero();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised register file for the ID stage. It is the successor to the fixed 32x32 file and adds configurable width and depth, an optional hardwired zero register, and optional same-cycle write-to-read bypass. It also includes a sequential debug dump engine that streams every register to the debug unit over a valid/ready handshake. Two combinational read ports feed the ID/EX register; one synchronous write port comes from WB.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NREGS = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports combinationally; 0 = reads return array contents only

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rs_addr  in  ADDR_W  read port A address
rt_addr  in  ADDR_W  read port B address
rs_data  out  DATA_W  read port A data (combinational)
rt_data  out  DATA_W  read port B data (combinational)
wr_en  in  1  write enable from WB
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
du_reg_addr  in  ADDR_W  debug peek address
du_reg_data  out  DATA_W  debug peek data (combinational, no bypass)
dump_start  in  1  start a full-file dump; sampled only in IDLE
dump_ready  in  1  debug unit accepts the current beat
dump_valid  out  1  dump beat valid
dump_addr  out  ADDR_W  index of the current dump beat
dump_data  out  DATA_W  contents of register dump_addr
dump_busy  out  1  high while the dump FSM is not IDLE
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (reset_n low, asynchronous): all NREGS entries clear to 0. dump_valid, dump_busy and dump_done go to 0, dump_addr to 0, FSM to IDLE. Reset mid-dump aborts the dump with no done pulse.
- Write: at posedge clk, if wr_en is 1 the array takes wr_data at wr_addr. The write is dropped when ZERO_REG=1 and wr_addr=0.
- Read, zero rule: with ZERO_REG=1, any read of address 0 returns 0. This applies to rs, rt, du and dump reads.
- Read, bypass: with BYPASS=1, if wr_en is 1, wr_addr equals the read address, and the write is not dropped, then rs_data/rt_data return wr_data in that same cycle. Otherwise they return array contents, so the result is visible the cycle after the write.
- Bypass scope: it also applies to dump_data. It never applies to du_reg_data.
- Both read ports may address the same register and both must return the same value.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start=1 moves to SEND with dump_addr=0. Otherwise stay.
  - SEND: dump_valid=1, dump_busy=1, dump_data shows register dump_addr (live contents, zero rule, bypass). On dump_valid and dump_ready:
    - if dump_addr = NREGS-1, go to DONE;
    - otherwise dump_addr increments by 1 next cycle.
    - Without ready, dump_addr holds; dump_data may change if that register is written. The value at the handshake cycle is the accepted one.
  - DONE: dump_valid=0, dump_busy=1, dump_done=1 for exactly one cycle, then IDLE with dump_addr reset to 0.
- dump_start is ignored in SEND and DONE. No queuing.
- Latency: a dump of N registers takes NREGS accepted beats. Minimum is NREGS+1 cycles from the start edge to the done pulse, with dump_ready held at 1.
- Pipeline writes proceed normally during a dump. The dump never stalls the write port.

Test Plan:
- Reset then read: drive reset_n low mid-run, read rs=3, rt=31, du=7 -> all return 0. dump_valid=0, dump_busy=0.
- Write/read and zero register (ZERO_REG=1): write 0xDEADBEEF to r5 and 0x1234 to r0, then read rs=5, rt=0 next cycle -> 0xDEADBEEF and 0. Repeat r0 with ZERO_REG=0 -> 0x1234.
- Bypass (BYPASS=1): wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5 with rs=rt=9 in the same cycle -> both read 0xA5A5A5A5 that cycle while du_reg_data(9) shows the old value. Same case with BYPASS=0 -> old value.
- Full dump, ready held high: preload r_i = i*0x11, pulse dump_start -> beats at addr 0..31 with data 0, 0x11..0x20F. dump_done pulses one cycle later. Total 33 cycles from start to done.
- Backpressure: dump_ready toggled pseudo-randomly, plus a write of 0x77 to r4 while addr 4 is stalled -> no beat lost or duplicated. Beat 4 is accepted with 0x77. dump_start during SEND is ignored.
- Reset mid-dump: assert reset_n=0 at beat 10 -> busy and valid drop immediately, no done pulse. A fresh dump_start after release restarts at addr 0 with all data 0.
